// File: rtl/i2c_master_tx.sv
// rtl/i2c_master_tx.sv - single-master I2C write engine: START, address, payload, STOP, flush pulse
module i2c_master_tx #(
  parameter int         CLK_DIV    = 250,
  parameter int         NUM_BYTES  = 33,
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  localparam int        W          = NUM_BYTES * 8,
  localparam int        CW         = $clog2(NUM_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          send,
  input  logic [W-1:0]  data_in,
  output logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          done,
  output logic          nack_err,
  output logic [CW-1:0] byte_cnt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] NB = CW'(NUM_BYTES);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, FLUSH, DONE
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_idx;
  logic [W-1:0]  shreg;
  logic [7:0]    addr_sh;
  logic [1:0]    sda_sync;
  logic          sda_low;
  logic          tick, slot_end, ack_sample;

  assign tick       = (div_cnt == DW'(CLK_DIV - 1));
  assign slot_end   = tick && (q == 2'd3);
  assign ack_sample = (q == 2'd3) && (div_cnt == '0) &&
                      ((state == ADDR_ACK) || (state == DATA_ACK));

  // Open-drain: only ever pull low, otherwise let the pull-up win.
  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    scl     = 1'b1;
    sda_low = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send) state_n = START;
      end
      START: begin
        sda_low = q[1];
        if (slot_end) state_n = ADDR;
      end
      ADDR: begin
        scl     = q[1];
        sda_low = ~addr_sh[7];
        if (slot_end && bit_idx == 3'd7) state_n = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl = q[1];
        if (slot_end) state_n = nack_err ? STOP : DATA;
      end
      DATA: begin
        scl     = q[1];
        sda_low = ~shreg[W-1];
        if (slot_end && bit_idx == 3'd7) state_n = DATA_ACK;
      end
      DATA_ACK: begin
        scl = q[1];
        if (slot_end) begin
          if (nack_err || byte_cnt >= NB - CW'(1)) state_n = STOP;
          else                                     state_n = DATA;
        end
      end
      STOP: begin
        scl     = q[1];
        sda_low = (q != 2'd3);
        // A NACKed frame skips the flush pulse so the slave never reports completion.
        if (slot_end) state_n = nack_err ? DONE : FLUSH;
      end
      FLUSH: begin
        scl = q[1];
        if (slot_end) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      q        <= 2'd0;
      bit_idx  <= 3'd0;
      shreg    <= '0;
      addr_sh  <= 8'h00;
      nack_err <= 1'b0;
      byte_cnt <= '0;
      sda_sync <= 2'b11;
    end else begin
      sda_sync <= {sda_sync[0], sda};
      if (state == IDLE || state == DONE) begin
        div_cnt <= '0;
        q       <= 2'd0;
        if (state == IDLE && send) begin
          shreg    <= data_in;
          addr_sh  <= {SLAVE_ADDR, 1'b0};
          nack_err <= 1'b0;
          byte_cnt <= '0;
          bit_idx  <= 3'd0;
        end
      end else begin
        if (tick) begin
          div_cnt <= '0;
          q       <= q + 2'd1;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        // Sampled mid-high-phase; the decision is taken at the slot end.
        if (ack_sample && sda_sync[1]) nack_err <= 1'b1;
        if (slot_end) begin
          case (state)
            ADDR: begin
              addr_sh <= {addr_sh[6:0], 1'b0};
              bit_idx <= bit_idx + 3'd1;
            end
            DATA: begin
              shreg   <= {shreg[W-2:0], 1'b0};
              bit_idx <= bit_idx + 3'd1;
            end
            DATA_ACK: begin
              if (!nack_err && byte_cnt < NB) byte_cnt <= byte_cnt + CW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb/tb_i2c_master_tx.sv - scoreboard bench for i2c_master_tx with a bus-level slave model
module tb_i2c_master_tx;

  localparam int CLK_DIV = 4;
  localparam int NB      = 33;
  localparam int W       = NB * 8;
  // 309 slots of 4 quarters, counting the accept edge as clock 1.
  localparam int LAT_OK  = 1236 * CLK_DIV + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         send = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         scl, busy, done, nack_err;
  logic [5:0]   byte_cnt;
  wire          sda;
  logic         slv_drive = 1'b0;

  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_tx #(.CLK_DIV(CLK_DIV), .NUM_BYTES(NB), .SLAVE_ADDR(7'h6A)) dut (
    .clk(clk), .reset(rst), .send(send), .data_in(data_in), .scl(scl), .sda(sda),
    .busy(busy), .done(done), .nack_err(nack_err), .byte_cnt(byte_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int nack;
    int cnt;
    int flush;
    int starts;
    int stops;
    int lat;
  } res_t;

  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];

  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pb(input int pat, input int k);
    case (pat)
      1:       return 8'(k * 7 + 17);
      2:       return 8'(8'hF0 ^ k);
      3:       return 8'(255 - k);
      4:       return 8'(k ^ 8'h5A);
      default: return 8'(k);
    endcase
  endfunction

  function automatic logic [W-1:0] mk(input int pat);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < NB; k++) d[W-1-8*k -: 8] = pb(pat, k);
    return d;
  endfunction

  task automatic push_frame(input int pat, input int n);
    exp_bytes.push_back(8'hD4);
    for (int k = 0; k < n; k++) exp_bytes.push_back(pb(pat, k));
  endtask

  // ---------------- slave model ----------------
  logic [6:0] slv_addr = 7'h6A;
  int         nack_at = 99;
  logic       p_scl = 1'b1, p_sda = 1'b1, c_sda;
  logic       in_frame = 1'b0, first = 1'b0, acking = 1'b0, ack_go = 1'b0, after_stop = 1'b0;
  logic [7:0] sh = 8'h00;
  int         bitc = 0, byte_idx = 0, starts = 0, stops = 0, flush_cnt = 0, rx_bytes = 0;

  always @(negedge clk) begin
    c_sda = sda;
    if (scl && p_scl && p_sda && !c_sda) begin
      starts++;
      in_frame = 1'b1; first = 1'b1; bitc = 0; byte_idx = 0;
      after_stop = 1'b0; flush_cnt = 0; acking = 1'b0; slv_drive = 1'b0;
    end else if (scl && p_scl && !p_sda && c_sda) begin
      stops++;
      in_frame = 1'b0; after_stop = 1'b1; bitc = 0;
    end else if (scl && !p_scl) begin
      if (after_stop) flush_cnt++;
      else if (in_frame && bitc < 8) begin
        sh = {sh[6:0], c_sda};
        bitc++;
        if (bitc == 8) begin
          if (first) begin
            first  = 1'b0;
            ack_go = (sh == {slv_addr, 1'b0});
          end else begin
            ack_go = (byte_idx != nack_at);
            byte_idx++;
          end
          rx_bytes++;
          if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_byte: got %0h expected no byte", sh);
          end else begin
            check("rx_byte", sh, exp_bytes.pop_front());
          end
        end
      end
    end else if (!scl && p_scl && in_frame) begin
      if (acking) begin
        slv_drive = 1'b0; acking = 1'b0; bitc = 0;
      end else if (bitc == 8) begin
        acking = 1'b1; slv_drive = ack_go;
      end
    end
    p_scl = scl;
    p_sda = c_sda;
  end

  // ---------------- completion monitor ----------------
  res_t r;
  int   last_starts = 0, last_stops = 0;

  always @(negedge clk) begin
    if (done) begin
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_pulse: got unexpected done expected none");
      end else begin
        r = exp_res.pop_front();
        check("nack_err", nack_err, r.nack);
        check("byte_cnt", byte_cnt, r.cnt);
        check("flush_pulses", flush_cnt, r.flush);
        check("start_count", starts - last_starts, r.starts);
        if (r.stops >= 0) check("stop_count", stops - last_stops, r.stops);
        check("done_latency", cyc - acc_cyc + 1, r.lat);
      end
      last_starts = starts;
      last_stops  = stops;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_send(input logic [W-1:0] d);
    data_in = d;
    send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_scl", scl, 1);
    check("reset_sda", sda, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_nack", nack_err, 0);
    check("reset_byte_cnt", byte_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full frame; extra send pulses and data_in changes while busy must be ignored.
    push_frame(0, 33);
    exp_res.push_back('{0, 33, 1, 1, 1, LAT_OK});
    do_send(264'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20);
    check("busy_after_accept", busy, 1);
    repeat (100) @(negedge clk);
    data_in = mk(1);
    for (int i = 0; i < 3; i++) begin
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat (50) @(negedge clk);
    end
    wait_done(6000);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("done_width", done, 0);
    repeat (4) @(negedge clk);
    check("send_in_done_ignored", busy, 0);

    // Address NACK, then a back-to-back frame NACKed on its 5th payload byte.
    slv_addr = 7'h55;
    exp_bytes.push_back(8'hD4);
    exp_res.push_back('{1, 0, 0, 1, 1, 177});
    do_send(mk(1));
    wait_done(1000);
    slv_addr = 7'h6A;
    nack_at = 4;
    push_frame(2, 5);
    exp_res.push_back('{1, 4, 0, 1, 1, 897});
    @(negedge clk);
    do_send(mk(2));
    check("nack_cleared_on_accept", nack_err, 0);
    check("busy_back_to_back", busy, 1);
    wait_done(2000);
    nack_at = 99;

    // Reset during the 10th payload byte.
    @(negedge clk);
    push_frame(3, 9);
    base = rx_bytes;
    do_send(mk(3));
    n = 0;
    while (rx_bytes < base + 10 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (rx_bytes < base + 10) begin
      checks++; errors++;
      $display("FAIL rx_timeout: got %0d bytes expected %0d", rx_bytes - base, 10);
    end
    repeat (3 * 4 * CLK_DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_scl", scl, 1);
    check("midreset_sda", sda, 1);
    check("midreset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    push_frame(4, 33);
    exp_res.push_back('{0, 33, 1, 2, -1, LAT_OK});
    do_send(mk(4));
    wait_done(6000);

    repeat (20) @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("results_left", exp_res.size(), 0);
    check("idle_at_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
